// File: rtl/mem_byte_sequencer.sv
// Byte-serial load/store sequencer between the MEM stage and a byte-wide,
// single-port, synchronous-read data RAM (big-endian multi-byte accesses).
module mem_byte_sequencer #(
    parameter int unsigned MEM_BYTES = 4000,
    parameter int unsigned ADDR_W    = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [1:0]        req_load_mode,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              req_ready,
    output logic              stall,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t            state, state_next;
    logic [2:0]        cnt;
    logic [ADDR_W-1:0] addr_r, addr_hold, addr_cur;
    logic [31:0]       wdata_r;
    logic [1:0]        mode_r;
    logic [23:0]       asm_r;
    logic [31:0]       asm_next, load_result;
    logic [7:0]        wdata_hold, wr_byte;
    logic              accept, reject;
    logic [2:0]        req_bytes, cur_bytes;
    logic [32:0]       req_last;

    always_comb begin
        req_ready = (state == IDLE) && !reset;
        accept    = req_valid && req_ready;
        req_bytes = (req_write || req_load_mode == 2'b00) ? 3'd4 : 3'd2;
        // 33-bit sum so addresses near the top of the 32-bit space cannot wrap
        req_last  = {1'b0, req_addr} + {30'b0, req_bytes} - 33'd1;
        reject    = (!req_write && req_load_mode == 2'b11) || (req_last >= 33'(MEM_BYTES));

        cur_bytes = (mode_r == 2'b00) ? 3'd4 : 3'd2;
        addr_cur  = addr_r + ADDR_W'(cnt);
        asm_next  = {asm_r, ram_rdata};

        case (cnt[1:0])
            2'd0:    wr_byte = wdata_r[31:24];
            2'd1:    wr_byte = wdata_r[23:16];
            2'd2:    wr_byte = wdata_r[15:8];
            default: wr_byte = wdata_r[7:0];
        endcase

        case (mode_r)
            2'b01:   load_result = {{16{asm_next[15]}}, asm_next[15:0]};
            2'b10:   load_result = {16'b0, asm_next[15:0]};
            default: load_result = asm_next;
        endcase

        stall     = !reset && ((state == IDLE && req_valid) || state == READ || state == WRITE);
        ram_we    = (state == WRITE);
        ram_addr  = addr_hold;
        ram_wdata = wdata_hold;
        if (state == WRITE || (state == READ && cnt != cur_bytes))
            ram_addr = addr_cur;
        if (state == WRITE)
            ram_wdata = wr_byte;

        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = reject ? DONE : (req_write ? WRITE : READ);
            READ:    if (cnt == cur_bytes) state_next = DONE;
            WRITE:   if (cnt == 3'd3) state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            resp_valid <= 1'b0;
            err        <= 1'b0;
            resp_rdata <= '0;
            addr_hold  <= '0;
            wdata_hold <= '0;
            addr_r     <= '0;
            wdata_r    <= '0;
            mode_r     <= '0;
            asm_r      <= '0;
        end else begin
            state      <= state_next;
            resp_valid <= (state_next == DONE);
            err        <= accept && reject;
            if (accept) begin
                addr_r  <= req_addr[ADDR_W-1:0];
                wdata_r <= req_wdata;
                mode_r  <= req_load_mode;
                cnt     <= '0;
                if (reject)
                    resp_rdata <= '0;
            end
            // read data lags the address by one cycle, so capture starts on the second READ cycle
            if (state == READ) begin
                if (cnt != '0)
                    asm_r <= asm_next[23:0];
                if (cnt != cur_bytes) begin
                    cnt       <= cnt + 3'd1;
                    addr_hold <= addr_cur;
                end else begin
                    resp_rdata <= load_result;
                end
            end
            if (state == WRITE) begin
                cnt        <= cnt + 3'd1;
                addr_hold  <= addr_cur;
                wdata_hold <= wr_byte;
            end
        end
    end

endmodule

// File: tb/tb_mem_byte_sequencer.sv
// Bench for mem_byte_sequencer: byte RAM, request-level reference model checked
// every cycle, plus directed requests with hand-computed results.
module tb_mem_byte_sequencer;

    logic        clk = 1'b0;
    logic        reset, req_valid, req_write;
    logic [1:0]  req_load_mode;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, stall, resp_valid, err, ram_we;
    logic [31:0] resp_rdata;
    logic [11:0] ram_addr;
    logic [7:0]  ram_wdata, ram_rdata;

    always #5 clk = ~clk;

    mem_byte_sequencer #(.MEM_BYTES(4000), .ADDR_W(12)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_load_mode(req_load_mode), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .stall(stall), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .err(err), .ram_addr(ram_addr), .ram_we(ram_we),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    logic [7:0]  ram     [0:4095];
    logic [7:0]  ref_mem [0:4095];
    logic        bd_we;
    logic [11:0] bd_addr;
    logic [7:0]  bd_data;

    always @(posedge clk) begin
        if (bd_we) ram[bd_addr] <= bd_data;
        else if (ram_we) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Request-level reference model: latency per request class, byte-lane timing of stores
    bit          armed = 0, prev_reset = 0;
    bit          m_busy = 0, m_reject, m_write;
    int          m_t0, m_len, m_n;
    logic [1:0]  m_mode;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [31:0] m_last_rdata = '0;

    always @(negedge clk) begin
        int rel, a;
        logic exp_ready, exp_stall, exp_rv, exp_err, exp_we;
        logic [31:0] b, w;
        if (!armed) begin
            armed      = reset;
            prev_reset = reset;
        end else begin
            exp_ready = !reset && !m_busy;
            exp_stall = 1'b0;
            exp_rv    = 1'b0;
            exp_err   = 1'b0;
            exp_we    = 1'b0;
            if (prev_reset) begin
                chk("rst_rdata", resp_rdata, 32'h0);
                chk("rst_ram_addr", 32'(ram_addr), 32'h0);
                chk("rst_ram_wdata", 32'(ram_wdata), 32'h0);
            end
            if (!m_busy) begin
                if (!reset && req_valid) begin
                    exp_stall = 1'b1;
                    m_busy   = 1;
                    m_t0     = cyc;
                    m_write  = req_write;
                    m_mode   = req_load_mode;
                    m_addr   = req_addr;
                    m_wdata  = req_wdata;
                    m_n      = (req_write || req_load_mode == 2'b00) ? 4 : 2;
                    m_reject = (!req_write && req_load_mode == 2'b11) ||
                               ((64'(req_addr) + 64'(m_n) - 64'd1) >= 64'd4000);
                    m_len    = m_reject ? 1 : (m_write ? 5 : m_n + 2);
                    if (m_reject) m_rdata = '0;
                    else if (m_write) m_rdata = m_last_rdata;
                    else begin
                        a = int'(req_addr[11:0]);
                        w = {ref_mem[a], ref_mem[a+1], ref_mem[a+2], ref_mem[a+3]};
                        if (m_n == 4) m_rdata = w;
                        else if (m_mode == 2'b01) m_rdata = {{16{w[31]}}, w[31:16]};
                        else m_rdata = {16'b0, w[31:16]};
                    end
                end
            end else begin
                rel = cyc - m_t0;
                if (rel == m_len) begin
                    exp_rv  = 1'b1;
                    exp_err = m_reject;
                end else begin
                    exp_stall = !reset;
                end
                if (!m_reject && m_write && rel >= 1 && rel <= 4) begin
                    exp_we = 1'b1;
                    b = m_wdata << (8 * (rel - 1));
                    a = int'((m_addr + 32'(rel) - 32'd1) & 32'hFFF);
                    chk("st_addr", 32'(ram_addr), 32'(a));
                    chk("st_byte", 32'(ram_wdata), 32'(b[31:24]));
                    ref_mem[a] = b[31:24];
                end
                if (!m_reject && !m_write && rel >= 1 && rel <= m_n)
                    chk("ld_addr", 32'(ram_addr), (m_addr + 32'(rel) - 32'd1) & 32'hFFF);
            end
            chk("req_ready", 32'(req_ready), 32'(exp_ready));
            chk("stall", 32'(stall), 32'(exp_stall));
            chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
            chk("err", 32'(err), 32'(exp_err));
            chk("ram_we", 32'(ram_we), 32'(exp_we));
            if (exp_rv) begin
                chk("resp_rdata", resp_rdata, m_rdata);
                m_busy       = 0;
                m_last_rdata = m_rdata;
            end
            if (reset) begin
                m_busy       = 0;
                m_last_rdata = '0;
            end
            prev_reset = reset;
        end
    end

    task automatic poke(input int a, input logic [7:0] d);
        bd_we = 1'b1;
        bd_addr = 12'(a);
        bd_data = d;
        ref_mem[a] = d;
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    task automatic present(input logic w, input logic [1:0] m, input logic [31:0] a,
                           input logic [31:0] d, output int t_acc);
        bit got = 0;
        req_valid = 1'b1;
        req_write = w;
        req_load_mode = m;
        req_addr = a;
        req_wdata = d;
        t_acc = -1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (req_ready) begin
                got = 1;
                t_acc = cyc;
            end
            @(posedge clk); #1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no acceptance expected acceptance within 40 cycles");
        end
    endtask

    task automatic wait_resp(input int t_acc, output int lat, output logic [31:0] rd, output logic e);
        lat = -1;
        rd = '0;
        e = 1'b0;
        for (int i = 0; i < 20 && lat < 0; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = cyc - t_acc;
                rd = resp_rdata;
                e = err;
            end
        end
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout: got no resp_valid expected one within 20 cycles");
        end
    endtask

    task automatic issue(input logic w, input logic [1:0] m, input logic [31:0] a,
                         input logic [31:0] d, output int lat, output logic [31:0] rd, output logic e);
        int t;
        @(posedge clk); #1;
        present(w, m, a, d, t);
        req_valid = 1'b0;
        wait_resp(t, lat, rd, e);
    endtask

    int img_addr [0:17] = '{8, 9, 10, 11, 100, 101, 102, 103, 200, 201,
                            301, 302, 303, 304, 3996, 3997, 3998, 3999};

    initial begin
        int lat, ta, tb, nresp;
        logic [31:0] rd;
        logic e;
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_load_mode = 2'b00;
        req_addr = '0; req_wdata = '0; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        repeat (2) @(posedge clk);
        #1;
        poke(8, 8'hAA); poke(9, 8'hBB); poke(10, 8'hCC); poke(11, 8'hDD);
        for (int i = 100; i < 104; i++) poke(i, 8'h00);
        for (int i = 301; i < 305; i++) poke(i, 8'h00);
        poke(200, 8'h80); poke(201, 8'h01);
        poke(3996, 8'h01); poke(3997, 8'h23); poke(3998, 8'h45); poke(3999, 8'h67);
        reset = 1'b0;

        issue(1'b1, 2'b00, 32'd100, 32'hDEADBEEF, lat, rd, e);
        chk("store_lat", 32'(lat), 32'd5);
        chk("store_err", 32'(e), 32'd0);
        issue(1'b0, 2'b00, 32'd100, 32'h0, lat, rd, e);
        chk("load_lat", 32'(lat), 32'd6);
        chk("load_word", rd, 32'hDEADBEEF);

        issue(1'b0, 2'b01, 32'd200, 32'h0, lat, rd, e);
        chk("half_s_lat", 32'(lat), 32'd4);
        chk("half_s", rd, 32'hFFFF8001);
        issue(1'b0, 2'b10, 32'd200, 32'h0, lat, rd, e);
        chk("half_u_lat", 32'(lat), 32'd4);
        chk("half_u", rd, 32'h00008001);

        issue(1'b0, 2'b11, 32'd0, 32'h0, lat, rd, e);
        chk("mode11_lat", 32'(lat), 32'd1);
        chk("mode11_err", 32'(e), 32'd1);
        chk("mode11_rdata", rd, 32'h0);
        issue(1'b0, 2'b00, 32'd3997, 32'h0, lat, rd, e);
        chk("oob_lat", 32'(lat), 32'd1);
        chk("oob_err", 32'(e), 32'd1);
        chk("oob_rdata", rd, 32'h0);
        issue(1'b0, 2'b00, 32'd3996, 32'h0, lat, rd, e);
        chk("edge_err", 32'(e), 32'd0);
        chk("edge_word", rd, 32'h01234567);
        issue(1'b1, 2'b00, 32'hFFFFFFFE, 32'h12345678, lat, rd, e);
        chk("wrap_lat", 32'(lat), 32'd1);
        chk("wrap_err", 32'(e), 32'd1);

        issue(1'b1, 2'b00, 32'd301, 32'hCAFEF00D, lat, rd, e);
        chk("mis_store_rdata", rd, 32'h0);
        issue(1'b0, 2'b00, 32'd301, 32'h0, lat, rd, e);
        chk("mis_word", rd, 32'hCAFEF00D);
        issue(1'b0, 2'b10, 32'd302, 32'h0, lat, rd, e);
        chk("mis_half_u", rd, 32'h0000FEF0);
        issue(1'b0, 2'b01, 32'd303, 32'h0, lat, rd, e);
        chk("mis_half_s", rd, 32'hFFFFF00D);

        @(posedge clk); #1;
        present(1'b0, 2'b00, 32'd100, 32'h0, ta);
        present(1'b0, 2'b01, 32'd200, 32'h0, tb);
        req_valid = 1'b0;
        chk("b2b_accept_gap", 32'(tb - ta), 32'd7);
        wait_resp(tb, lat, rd, e);
        chk("b2b_lat", 32'(lat), 32'd4);
        chk("b2b_data", rd, 32'hFFFF8001);

        @(posedge clk); #1;
        present(1'b1, 2'b00, 32'd8, 32'h11223344, ta);
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rdata_lit", resp_rdata, 32'h0);
        chk("rst_idle_ready", 32'(req_ready), 32'd1);
        nresp = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (resp_valid) nresp++;
        end
        chk("rst_no_resp", 32'(nresp), 32'd0);

        chk("ram100", 32'(ram[100]), 32'hDE);
        chk("ram101", 32'(ram[101]), 32'hAD);
        chk("ram102", 32'(ram[102]), 32'hBE);
        chk("ram103", 32'(ram[103]), 32'hEF);
        chk("ram8", 32'(ram[8]), 32'h11);
        chk("ram9", 32'(ram[9]), 32'h22);
        chk("ram10", 32'(ram[10]), 32'hCC);
        chk("ram11", 32'(ram[11]), 32'hDD);
        for (int i = 0; i < 18; i++)
            chk("ram_image", 32'(ram[img_addr[i]]), 32'(ref_mem[img_addr[i]]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected $finish before 200000 time units");
        $fatal(1);
    end

endmodule

// File: doc/mem_byte_sequencer.md
# mem_byte_sequencer

Multi-cycle controller between the MEM pipeline stage and a byte-wide, single-port, synchronous-read data RAM. It accepts one load or store request at a time and issues the 2 or 4 big-endian byte accesses one per cycle. For loads it assembles and extends the result, and it holds the pipeline via `stall` until a one-cycle `resp_valid` completes the request. It replaces the combinational multi-byte access in the MEM stage with a realistic, single-ported memory model.

## Interface
- `MEM_BYTES`, default 4000: number of addressable RAM bytes; valid byte addresses are 0..MEM_BYTES-1.
- `ADDR_W`, default 12: width of `ram_addr`; must satisfy 2^ADDR_W >= MEM_BYTES.

- `clk`, in, 1: the single clock; all state changes on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `req_valid`, in, 1: the MEM stage presents a request. It is held stable until accepted.
- `req_write`, in, 1: 1 = word store, 0 = load.
- `req_load_mode`, in, 2: load format. 00 = word, 01 = signed half, 10 = unsigned half, 11 = illegal. Ignored for stores.
- `req_addr`, in, 32: byte address of the most-significant byte.
- `req_wdata`, in, 32: store data.
- `req_ready`, out, 1: combinational; the request is accepted this cycle.
- `stall`, out, 1: combinational; the pipeline must freeze.
- `resp_valid`, out, 1: registered; one-cycle completion pulse.
- `resp_rdata`, out, 32: registered load result. Valid while `resp_valid` is high for loads.
- `err`, out, 1: registered; high together with `resp_valid` when the request was rejected.
- `ram_addr`, out, ADDR_W: RAM byte address.
- `ram_we`, out, 1: RAM write enable.
- `ram_wdata`, out, 8: RAM write byte.
- `ram_rdata`, in, 8: RAM read byte. It reflects the `ram_addr` sampled at the previous rising edge.

## Operation
- FSM states: IDLE, READ, WRITE, DONE. Reset state is IDLE.
- `req_ready` = (state == IDLE) && !reset. Acceptance happens when `req_valid` && `req_ready`. On acceptance the block latches addr, wdata, mode and write, and clears byte counter `cnt`.
- Byte count N: 4 for a store or mode 00; 2 for mode 01 or 10.
- Rejection: the request is rejected if it is a load with mode 11, or if {1'b0,req_addr} + N - 1 >= MEM_BYTES. This check uses 33-bit arithmetic, so addresses near 0xFFFFFFFF do not wrap.
  - A rejected request goes IDLE -> DONE.
  - `err` = 1 and `resp_rdata` = 0 in DONE.
  - No RAM cycle is issued.
- Misaligned addresses are legal and are not rejected.
- READ (N+1 cycles):
  - While cnt < N: `ram_addr` = addr + cnt, then cnt increments.
  - Every READ cycle after the first shifts `ram_rdata` into an assembly register, MSB first.
  - After the (N+1)th cycle the FSM goes to DONE.
- WRITE (4 cycles):
  - Drive `ram_we` = 1 and `ram_addr` = addr + cnt.
  - `ram_wdata` = wdata[31-8*cnt -: 8], so byte 0 is wdata[31:24].
  - After cnt = 3 the FSM goes to DONE.
- DONE (1 cycle): `resp_valid` = 1, then the FSM goes to IDLE.
- Load result formatting in DONE:
  - Mode 00: the assembled 32 bits.
  - Mode 01: {{16{h[15]}}, h}, where h is the assembled half.
  - Mode 10: {16'b0, h}.
- Store completion: `resp_rdata` holds its previous value and `err` = 0.
- `stall` = !reset && ((state == IDLE && req_valid) || state == READ || state == WRITE). `stall` is 0 in DONE, so the pipeline advances in the `resp_valid` cycle.
- Requests in READ, WRITE or DONE are not accepted; the requester holds them.
- Reset mid-operation:
  - The FSM returns to IDLE immediately.
  - No `resp_valid` is produced.
  - Bytes already written by a partial store remain in RAM.
- Reset values: `resp_valid`, `err` = 0; `resp_rdata` = 0; `ram_we` = 0; `ram_addr` = 0; `ram_wdata` = 0; cnt = 0. While `reset` is high, `req_ready` = `stall` = 0.
- `ram_we` is 0 in every state except WRITE. `ram_addr` and `ram_wdata` hold their last values outside READ and WRITE.

## Timing
- Latency is measured from the acceptance cycle (cycle 0) to the `resp_valid` cycle:
  - Word load: 6 cycles. Issues in cycles 1–4; bytes are captured in cycles 2–5.
  - Half load: 4 cycles.
  - Store: 5 cycles. Writes in cycles 1–4.
  - Rejected request: 1 cycle.
- Back-to-back throughput: the next acceptance is at the earliest in the cycle after DONE. Word loads sustain 1 per 7 cycles; stores 1 per 6 cycles.
- `stall` is high in cycles 0..latency-1 and low in the `resp_valid` cycle.

## Test plan
- Store 0xDEADBEEF at addr 100, then word load at 100.
  - Required: RAM[100..103] = DE, AD, BE, EF.
  - Store: `resp_valid` 5 cycles after acceptance.
  - Load: `resp_rdata` = 0xDEADBEEF, `resp_valid` 6 cycles after acceptance, `stall` high for cycles 0–5.
- RAM[200..201] = 0x80, 0x01.
  - Mode 01 -> 0xFFFF8001. Mode 10 -> 0x00008001. Each has latency 4.
- Load mode 11 at addr 0, and word load at addr 3997 with MEM_BYTES = 4000.
  - Required for each: `resp_valid` and `err` = 1 in cycle 1, `resp_rdata` = 0, `ram_we` never asserted.
  - Word load at 3996 completes with `err` = 0.
- Assert `reset` in cycle 2 of a store of 0x11223344 at addr 8.
  - Required: RAM[8] = 0x11, RAM[9] = 0x22, RAM[10..11] unchanged.
  - FSM in IDLE next cycle, no `resp_valid`, all registered outputs 0.
- Hold a second request from the acceptance cycle of a first.
  - Required: `req_ready` = 0 until the cycle after DONE.
  - The second request is accepted exactly once and completes with the correct data.
- Store at addr 0xFFFFFFFE.
  - Required: rejected (`err` = 1) with no RAM write.
